// File: rtl/pid_ctrl_if.sv
// Sample-in / control-word-out bundle between the pitch estimator and the PID compensator.
// The master drives error samples and pwr_up; the slave returns the registered control word.
interface pid_ctrl_if;
    logic        err_vld;
    logic [15:0] ptch_err;
    logic        pwr_up;
    logic [11:0] PID_cntrl;
    logic        out_vld;

    modport master (
        output err_vld,
        output ptch_err,
        output pwr_up,
        input  PID_cntrl,
        input  out_vld
    );

    modport slave (
        input  err_vld,
        input  ptch_err,
        input  pwr_up,
        output PID_cntrl,
        output out_vld
    );
endinterface

// File: rtl/pid_ctrl.sv
// Saturating PID compensator: 16b pitch error in, 12b signed control word out, one cycle later.
// Output is registered; there is no backpressure, so every err_vld gives exactly one out_vld pulse.
module pid_ctrl #(
    parameter logic [4:0] P_COEFF = 5'd9,
    parameter logic [5:0] D_COEFF = 6'd6,
    parameter int         D_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    pid_ctrl_if.slave bus
);

    logic signed [9:0]  err_sat;
    logic signed [14:0] err_ext15;
    logic signed [14:0] p_gain;
    logic signed [14:0] p_term;

    logic signed [17:0] integ_q, integ_d;
    logic signed [17:0] integ_add;
    logic               integ_ovf;
    logic signed [11:0] i_term;

    logic signed [9:0]  hist_q [D_DEPTH];
    logic signed [9:0]  hist_d [D_DEPTH];
    logic signed [9:0]  prev_err;
    logic signed [10:0] d_diff;
    logic signed [6:0]  d_sat;
    logic signed [12:0] d_ext13;
    logic signed [12:0] d_gain;
    logic signed [12:0] d_term;

    logic signed [15:0] sum;
    logic        [11:0] pid_q, pid_d;
    logic               out_vld_q;

    // In range only when bits [15:9] are all copies of the sign bit.
    always_comb begin
        if (!bus.ptch_err[15] && (|bus.ptch_err[14:9])) begin
            err_sat = 10'h1FF;
        end else if (bus.ptch_err[15] && !(&bus.ptch_err[14:9])) begin
            err_sat = 10'h200;
        end else begin
            err_sat = bus.ptch_err[9:0];
        end
    end

    assign err_ext15 = {{5{err_sat[9]}}, err_sat};
    assign p_gain    = {10'd0, P_COEFF};
    assign p_term    = err_ext15 * p_gain;

    assign integ_add = integ_q + {{8{err_sat[9]}}, err_sat};
    assign integ_ovf = (integ_q[17] == err_sat[9]) && (integ_add[17] != integ_q[17]);

    // pwr_up low clears the integrator every cycle, even without a sample.
    always_comb begin
        if (!bus.pwr_up) begin
            integ_d = '0;
        end else if (bus.err_vld && !integ_ovf) begin
            integ_d = integ_add;
        end else begin
            integ_d = integ_q;
        end
    end

    assign i_term = integ_d[17:6];

    always_comb begin
        for (int i = 0; i < D_DEPTH; i++) begin
            hist_d[i] = hist_q[i];
        end
        if (bus.err_vld) begin
            hist_d[0] = err_sat;
            for (int i = 1; i < D_DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    assign prev_err = hist_q[D_DEPTH-1];
    assign d_diff   = {err_sat[9], err_sat} - {prev_err[9], prev_err};

    always_comb begin
        if (!d_diff[10] && (|d_diff[9:6])) begin
            d_sat = 7'h3F;
        end else if (d_diff[10] && !(&d_diff[9:6])) begin
            d_sat = 7'h40;
        end else begin
            d_sat = d_diff[6:0];
        end
    end

    assign d_ext13 = {{6{d_sat[6]}}, d_sat};
    assign d_gain  = {7'd0, D_COEFF};
    assign d_term  = d_ext13 * d_gain;

    assign sum = {p_term[14], p_term}
               + {{4{i_term[11]}}, i_term}
               + {{3{d_term[12]}}, d_term};

    always_comb begin
        if (!sum[15] && (|sum[14:11])) begin
            pid_d = 12'h7FF;
        end else if (sum[15] && !(&sum[14:11])) begin
            pid_d = 12'h800;
        end else begin
            pid_d = sum[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            integ_q   <= '0;
            pid_q     <= '0;
            out_vld_q <= 1'b0;
            for (int i = 0; i < D_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            integ_q   <= integ_d;
            out_vld_q <= bus.err_vld;
            if (bus.err_vld) begin
                pid_q <= pid_d;
            end
            for (int i = 0; i < D_DEPTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign bus.PID_cntrl = pid_q;
    assign bus.out_vld   = out_vld_q;

endmodule

// File: tb/tb_pid_ctrl.sv
// Directed bench for pid_ctrl with default gains (P=9, D=6, D_DEPTH=2).
module tb_pid_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    pid_ctrl_if bus ();

    pid_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present inputs for one rising edge, then settle just after it.
    task automatic cyc(input logic vld, input logic [15:0] e);
        bus.err_vld  = vld;
        bus.ptch_err = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b1, 16'h1234);
        cyc(1'b1, 16'h1234);
        rst_n = 1'b1;
        bus.err_vld = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.err_vld  = 1'b0;
        bus.ptch_err = 16'h0000;
        bus.pwr_up   = 1'b1;

        // Reset held with err_vld high
        do_reset();
        chk("reset_pid",   {20'd0, bus.PID_cntrl}, 32'h000);
        chk("reset_vld",   {31'd0, bus.out_vld},   32'd0);
        chk("reset_integ", {14'd0, dut.integ_q},   32'd0);

        // Small sample: P 18 + I 0 + D 12
        cyc(1'b1, 16'h0002);
        chk("small_pid", {20'd0, bus.PID_cntrl}, 32'h01E);
        chk("small_vld", {31'd0, bus.out_vld},   32'd1);
        cyc(1'b0, 16'h7FFF);
        chk("small_vld_drop", {31'd0, bus.out_vld},   32'd0);
        chk("small_hold",     {20'd0, bus.PID_cntrl}, 32'h01E);

        // Negative sample: -900 - 2 - 384
        do_reset();
        cyc(1'b1, 16'hFF9C);
        chk("neg_pid", {20'd0, bus.PID_cntrl}, 32'hAFA);
        chk("neg_vld", {31'd0, bus.out_vld},   32'd1);

        // Saturation extremes
        do_reset();
        cyc(1'b1, 16'h7FFF);
        chk("pos_sat", {20'd0, bus.PID_cntrl}, 32'h7FF);
        do_reset();
        cyc(1'b1, 16'h8000);
        chk("neg_sat", {20'd0, bus.PID_cntrl}, 32'h800);

        // Integrator overflow: 256 x 511 = 130816, 257th add would exceed 131071
        do_reset();
        for (int i = 0; i < 256; i++) cyc(1'b1, 16'h01FF);
        chk("integ_256", {14'd0, dut.integ_q}, 32'd130816);
        cyc(1'b1, 16'h01FF);
        chk("integ_257", {14'd0, dut.integ_q}, 32'd130816);
        chk("ovf_vld",   {31'd0, bus.out_vld}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h01FF);
        chk("integ_hold", {14'd0, dut.integ_q}, 32'd130816);
        // I_term 2044 from the held integrator; D sees 511 from two samples back
        cyc(1'b1, 16'h0000);
        chk("ovf_zero1", {20'd0, bus.PID_cntrl}, 32'h67C);
        cyc(1'b1, 16'h0000);
        chk("ovf_zero2", {20'd0, bus.PID_cntrl}, 32'h67C);
        cyc(1'b1, 16'h0000);
        chk("ovf_zero3", {20'd0, bus.PID_cntrl}, 32'h7FC);

        // pwr_up drop and derivative history
        do_reset();
        cyc(1'b1, 16'd64);
        chk("pw_s1", {20'd0, bus.PID_cntrl}, 32'h3BB);
        cyc(1'b1, 16'd64);
        chk("pw_s2",    {20'd0, bus.PID_cntrl}, 32'h3BC);
        chk("pw_integ", {14'd0, dut.integ_q},   32'd128);
        bus.pwr_up = 1'b0;
        cyc(1'b1, 16'd0);
        chk("pw_drop_pid",   {20'd0, bus.PID_cntrl}, 32'hE80);
        chk("pw_drop_integ", {14'd0, dut.integ_q},   32'd0);
        cyc(1'b1, 16'd0);
        chk("pw_zero2", {20'd0, bus.PID_cntrl}, 32'hE80);
        cyc(1'b1, 16'd10);
        chk("pw_d10", {20'd0, bus.PID_cntrl}, 32'h096);
        cyc(1'b0, 16'd0);
        cyc(1'b0, 16'd0);
        chk("pw_idle_integ", {14'd0, dut.integ_q}, 32'd0);
        chk("pw_idle_hold",  {20'd0, bus.PID_cntrl}, 32'h096);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pid_ctrl.md
# pid_ctrl

Signed PID compensator for the balance loop; consumes the raw 16-bit signed pitch error each sample and produces a registered, saturated 12-bit signed control word for the motor-drive stage. Internally applies the team's standard saturation rules (16→10-bit error, 10→7-bit derivative) ahead of the P/I/D arithmetic. Adds the stateful parts the combinational saturator lacks: the integrator with overflow hold, the derivative history queue, and a valid-qualified output register.

## Interface
- P_COEFF, 9, unsigned 5-bit proportional gain
- D_COEFF, 6, unsigned 6-bit derivative gain
- D_DEPTH, 2, number of accepted samples back used for the derivative difference (≥1)
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- err_vld  input  1  ptch_err holds a new sample this cycle (single-cycle pulse, any rate)
- ptch_err  input  16  signed pitch error
- pwr_up  input  1  high = rider on / loop enabled; low = integrator forced to 0
- PID_cntrl  output  12  signed control word, registered
- out_vld  output  1  one-cycle pulse, PID_cntrl updated this cycle

## Operation
- err_sat (10b signed): ptch_err clamped to [-512, 511] (0x200 / 0x1FF); in-range values pass bits [9:0].
- P_term (15b signed) = err_sat × P_COEFF (gain zero-extended, signed multiply).
- Integrator integ (18b signed): on err_vld, integ_nxt = integ + sext(err_sat). Overflow (both operands same sign, sum sign differs) → integ holds. pwr_up low → integ cleared to 0 every cycle, overriding err_vld.
- I_term (12b signed) = integ_nxt[17:6] (arithmetic, floor toward −∞); integ_nxt is the post-update value (0 when pwr_up low).
- History queue: D_DEPTH entries of 10b err_sat, cleared to 0 on reset; on err_vld, shifts in err_sat regardless of pwr_up. prev_err = oldest entry (value from D_DEPTH accepted samples ago).
- D_diff (11b signed) = err_sat − prev_err; saturated to 7b signed [-64, 63] (0x40 / 0x3F).
- D_term (13b signed) = D_diff_sat × D_COEFF.
- sum (16b signed) = sext(P_term) + sext(I_term) + sext(D_term); PID_cntrl = sum clamped to [-2048, 2047] (0x800 / 0x7FF).
- err_vld low: PID_cntrl, integ, queue hold; out_vld low.

## Timing
- Reset (rst_n low at edge): PID_cntrl = 0, out_vld = 0, integ = 0, all queue entries = 0. Reset wins over err_vld in the same cycle; mid-operation reset discards in-flight sample.
- Latency: sample with err_vld high in cycle N → PID_cntrl valid and out_vld high in cycle N+1; integ and queue updated at the same edge.
- Back-to-back err_vld every cycle supported at full throughput; each accepted sample yields exactly one out_vld pulse.
- pwr_up falling while err_vld high: integ → 0 and I_term = 0 for that sample; P and D still computed.
- No input backpressure; ptch_err sampled only when err_vld high.

## Test plan
- Reset: hold rst_n low 2 cycles with err_vld=1, ptch_err=16'h1234 → PID_cntrl=0x000, out_vld=0; first err_vld after release starts from integ=0, queue=0.
- Small sample: after reset, pwr_up=1, one err_vld with ptch_err=16'h0002 → next cycle out_vld=1, PID_cntrl=0x01E (P 18 + I 0 + D 12); cycle after, out_vld=0.
- Negative sample: after reset, pwr_up=1, ptch_err=16'hFF9C (−100) → P −900, I −2, D_diff sat −64 → D −384; PID_cntrl=0xAFA (−1286).
- Saturation extremes: after reset, ptch_err=16'h7FFF → err_sat 511, PID_cntrl=0x7FF; after reset, ptch_err=16'h8000 → err_sat −512, PID_cntrl=0x800.
- Integrator overflow: pwr_up=1, 257 consecutive err_vld with ptch_err=16'h01FF → integ stops at 130816 (257th add would overflow), stays there on further samples.
- pwr_up/derivative: accumulate integ>0, drop pwr_up → integ=0 next edge and I_term=0; with D_DEPTH=2 feed 0,0,10 → third output D_diff=10, D_term=60; queue keeps shifting while pwr_up low.
